vs_spi_scheduler: RTL and testbench

//  Sole owner of the VS10xx decoder SPI pins (SCLK/MOSI/xCS/xDCS). Time-shares the
//  bus between two 32-bit word requesters: SCI (init/volume command words) and SDI
//  (bitstream words from block RAM). Gates each word start on DREQ, shifts MSB first,
//  and enforces an inter-word gap. Sits between the player FSM and the decoder pins.

---
 rtl/vs_spi_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_vs_spi_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vs_spi_scheduler.sv
// VS10xx SPI bus owner: arbitrates SCI/SDI 32-bit words, DREQ-gated, MSB first.
// Optional SCI read-back of the 16-bit data field when SCI_READ_EN is defined.
module vs_spi_scheduler #(
    parameter int CLK_DIV = 1,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        sci_req,
    input  logic [31:0] sci_wdata,
    output logic        sci_ack,
    input  logic        sdi_req,
    input  logic [31:0] sdi_wdata,
    output logic        sdi_ack,
    output logic        busy,
    input  logic        mp3_dreq,
    output logic        mp3_sclk,
    output logic        mp3_mosi,
    output logic        mp3_cs,
    output logic        mp3_dcs
`ifdef SCI_READ_EN
    ,
    input  logic        mp3_miso,
    output logic [15:0] sci_rdata
`endif
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_SCI,
        SHIFT_SDI,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_q, cs_d;
    logic          dcs_q, dcs_d;
    logic          sci_ack_q, sci_ack_d;
    logic          sdi_ack_q, sdi_ack_d;
    logic          busy_q, busy_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   grant_word;

`ifdef SCI_READ_EN
    logic          rd_q, rd_d;
    logic [15:0]   rd_sh_q, rd_sh_d;
    logic [15:0]   rdata_q, rdata_d;
`endif

    assign grant_word = sci_req ? sci_wdata : sdi_wdata;

    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        dcs_d     = dcs_q;
        sci_ack_d = 1'b0;
        sdi_ack_d = 1'b0;
        busy_d    = busy_q;
        shreg_d   = shreg_q;
        div_d     = div_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
`ifdef SCI_READ_EN
        rd_d      = rd_q;
        rd_sh_d   = rd_sh_q;
        rdata_d   = rdata_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mp3_dreq && (sci_req || sdi_req)) begin
                    shreg_d = grant_word;
                    mosi_d  = grant_word[31];
                    sclk_d  = 1'b0;
                    cs_d    = ~sci_req;
                    dcs_d   = sci_req;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = sci_req ? SHIFT_SCI : SHIFT_SDI;
`ifdef SCI_READ_EN
                    rd_d    = sci_req && (sci_wdata[31:24] == 8'h03);
`endif
                end
            end
            SHIFT_SCI, SHIFT_SDI: begin
                if (div_q == DIV_MAX) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
`ifdef SCI_READ_EN
                        // Data phase of a read: rising edges 17..32
                        if (state_q == SHIFT_SCI && rd_q && bit_q[4])
                            rd_sh_d = {rd_sh_q[14:0], mp3_miso};
`endif
                    end else if (bit_q == 5'd31) begin
                        cs_d      = 1'b1;
                        dcs_d     = 1'b1;
                        mosi_d    = 1'b0;
                        sci_ack_d = (state_q == SHIFT_SCI);
                        sdi_ack_d = (state_q == SHIFT_SDI);
                        gap_d     = '0;
`ifdef SCI_READ_EN
                        if (state_q == SHIFT_SCI && rd_q)
                            rdata_d = rd_sh_q;
`endif
                        if (GAP_CYC == 0) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shreg_d = {shreg_q[30:0], shreg_q[31]};
                        mosi_d  = shreg_q[30];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_MAX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q   <= IDLE;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            dcs_q     <= 1'b1;
            sci_ack_q <= 1'b0;
            sdi_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            shreg_q   <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
`ifdef SCI_READ_EN
            rd_q      <= 1'b0;
            rd_sh_q   <= '0;
            rdata_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            dcs_q     <= dcs_d;
            sci_ack_q <= sci_ack_d;
            sdi_ack_q <= sdi_ack_d;
            busy_q    <= busy_d;
            shreg_q   <= shreg_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
`ifdef SCI_READ_EN
            rd_q      <= rd_d;
            rd_sh_q   <= rd_sh_d;
            rdata_q   <= rdata_d;
`endif
        end
    end

    assign mp3_sclk = sclk_q;
    assign mp3_mosi = mosi_q;
    assign mp3_cs   = cs_q;
    assign mp3_dcs  = dcs_q;
    assign sci_ack  = sci_ack_q;
    assign sdi_ack  = sdi_ack_q;
    assign busy     = busy_q;
`ifdef SCI_READ_EN
    assign sci_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_vs_spi_scheduler.sv
// Bench for vs_spi_scheduler: bus monitor rebuilds words from the pins and
// compares order, timing and content against per-word arithmetic expectations.
module tb_vs_spi_scheduler;

    localparam int CLK_DIV  = 1;
    localparam int GAP_CYC  = 2;
    localparam int WORD_CYC = 64 * CLK_DIV;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        sci_req = 1'b0;
    logic [31:0] sci_wdata = '0;
    logic        sci_ack;
    logic        sdi_req = 1'b0;
    logic [31:0] sdi_wdata = '0;
    logic        sdi_ack;
    logic        busy;
    logic        mp3_dreq = 1'b0;
    logic        mp3_sclk;
    logic        mp3_mosi;
    logic        mp3_cs;
    logic        mp3_dcs;
`ifdef SCI_READ_EN
    logic        mp3_miso;
    logic [15:0] sci_rdata;
    logic [15:0] miso_pat = '0;
`endif

    vs_spi_scheduler #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk),
        .RST(RST),
        .sci_req(sci_req),
        .sci_wdata(sci_wdata),
        .sci_ack(sci_ack),
        .sdi_req(sdi_req),
        .sdi_wdata(sdi_wdata),
        .sdi_ack(sdi_ack),
        .busy(busy),
        .mp3_dreq(mp3_dreq),
        .mp3_sclk(mp3_sclk),
        .mp3_mosi(mp3_mosi),
        .mp3_cs(mp3_cs),
        .mp3_dcs(mp3_dcs)
`ifdef SCI_READ_EN
        ,
        .mp3_miso(mp3_miso),
        .sci_rdata(sci_rdata)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sci;
        logic [31:0] word;
        int          bits;
        int          start;
        int          len;
    } rec_t;

    rec_t recs[$];
    int   sci_acks[$];
    int   sdi_acks[$];
    int   cyc = 0;
    int   busy_cnt = 0;
    int   mon_bits = 0;
    bit   mon_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

`ifdef SCI_READ_EN
    // Decoder model: drives read data bit for the next rising edge
    assign mp3_miso = (mon_bits >= 16 && mon_bits < 32) ?
                      miso_pat[4'(31 - mon_bits)] : 1'b0;
`endif

    // Pin-level monitor: reassembles each framed word from SCLK/MOSI
    initial begin
        rec_t cur;
        bit   in_word;
        bit   sel;
        logic prev_sclk;
        in_word   = 1'b0;
        prev_sclk = 1'b0;
        cur       = '{sci: 1'b0, word: '0, bits: 0, start: 0, len: 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                sel = (mp3_cs === 1'b0) || (mp3_dcs === 1'b0);
                tests++;
                assert (!(mp3_cs === 1'b0 && mp3_dcs === 1'b0) &&
                        (sel || mp3_sclk === 1'b0))
                else begin
                    fails++;
                    $error("FAIL bus_idle cyc=%0d observed cs=%b dcs=%b sclk=%b expected one sel max, sclk 0 when idle",
                           cyc, mp3_cs, mp3_dcs, mp3_sclk);
                end
                if (busy === 1'b1) busy_cnt++;
                if (sel && !in_word) begin
                    in_word   = 1'b1;
                    cur.sci   = (mp3_cs === 1'b0);
                    cur.word  = '0;
                    cur.bits  = 0;
                    cur.start = cyc;
                    cur.len   = 0;
                end
                if (sel) begin
                    cur.len++;
                    if (mp3_sclk === 1'b1 && prev_sclk === 1'b0) begin
                        cur.word = {cur.word[30:0], mp3_mosi};
                        cur.bits++;
                    end
                end else if (in_word) begin
                    in_word = 1'b0;
                    recs.push_back(cur);
                end
                mon_bits = in_word ? cur.bits : 0;
                if (sci_ack === 1'b1) sci_acks.push_back(cyc);
                if (sdi_ack === 1'b1) sdi_acks.push_back(cyc);
            end
            prev_sclk = mp3_sclk;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        recs.delete();
        sci_acks.delete();
        sdi_acks.delete();
        busy_cnt = 0;
    endtask

    task automatic check_rec(input int idx, input bit sci,
                             input logic [31:0] w, input int g);
        if (recs.size() > idx) begin
            chk("word_sel_sci", recs[idx].sci, sci);
            chk("word_data", recs[idx].word, w);
            chk("word_bits", recs[idx].bits, 32);
            chk("word_grant_cyc", recs[idx].start, g);
            chk("word_sel_len", recs[idx].len, WORD_CYC);
        end
    endtask

    // One scenario from an idle bus; expectations from grant arithmetic
    task automatic run(input bit do_sci, input bit do_sdi,
                       input logic [31:0] wa, input logic [31:0] wb,
                       input int dly, input bit glitch);
        int c, g1, g2, n, budget, sdi_g;
        clear_mon();
        sci_wdata = wa;
        sdi_wdata = wb;
        mp3_dreq  = (dly == 0);
        sci_req   = do_sci;
        sdi_req   = do_sdi;
        c      = cyc;
        g1     = c + dly + 1;
        g2     = g1 + WORD_CYC + GAP_CYC + 1;
        n      = int'(do_sci) + int'(do_sdi);
        budget = dly + n * (WORD_CYC + GAP_CYC + 1) + 20;
        for (int i = 0; i < budget && (sci_req || sdi_req); i++) begin
            tick();
            if (cyc - c == dly) mp3_dreq = 1'b1;
            if (glitch && cyc == g1 + 19) mp3_dreq = 1'b0;
            if (glitch && cyc == g1 + 60) mp3_dreq = 1'b1;
            if (sci_ack === 1'b1) sci_req = 1'b0;
            if (sdi_ack === 1'b1) sdi_req = 1'b0;
        end
        chk("req_served", {30'd0, sci_req, sdi_req}, 32'd0);
        sci_req = 1'b0;
        sdi_req = 1'b0;
        mp3_dreq = 1'b1;
        for (int i = 0; i < GAP_CYC + 3; i++) tick();
        chk("word_count", recs.size(), n);
        check_rec(0, do_sci, do_sci ? wa : wb, g1);
        if (n == 2) check_rec(1, 1'b0, wb, g2);
        sdi_g = do_sci ? g2 : g1;
        chk("sci_ack_count", sci_acks.size(), int'(do_sci));
        chk("sdi_ack_count", sdi_acks.size(), int'(do_sdi));
        if (do_sci && sci_acks.size() > 0)
            chk("sci_ack_cyc", sci_acks[0], g1 + WORD_CYC);
        if (do_sdi && sdi_acks.size() > 0)
            chk("sdi_ack_cyc", sdi_acks[0], sdi_g + WORD_CYC);
        chk("busy_cycles", busy_cnt, n * (WORD_CYC + GAP_CYC));
    endtask

    initial begin
        logic [31:0] wa, wb;
        int          mode, dly;
        RST = 1'b0;
        tick();
        tick();
        chk("rst_cs", mp3_cs, 1);
        chk("rst_dcs", mp3_dcs, 1);
        chk("rst_sclk", mp3_sclk, 0);
        chk("rst_mosi", mp3_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {sci_ack, sdi_ack}, 0);
        RST = 1'b1;
        mon_en = 1'b1;
        tick();

        run(1'b1, 1'b0, 32'h020B2020, 32'h0, 0, 1'b0);
        run(1'b1, 1'b1, 32'h020B0808, 32'hDEADBEEF, 0, 1'b0);
        run(1'b0, 1'b1, 32'h0, 32'hC3A5_0F0F, 100, 1'b0);
        run(1'b0, 1'b1, 32'h0, 32'h8000_0001, 0, 1'b1);

        // Reset in the middle of an SDI word aborts it without ack
        clear_mon();
        sdi_wdata = 32'hFFFF_FFFF;
        sdi_req   = 1'b1;
        mp3_dreq  = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        RST = 1'b0;
        sdi_req = 1'b0;
        tick();
        chk("abort_cs", mp3_cs, 1);
        chk("abort_dcs", mp3_dcs, 1);
        chk("abort_sclk", mp3_sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack", sdi_ack, 0);
        RST = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_ack", sdi_acks.size(), 0);
        chk("abort_words", recs.size(), 1);
        if (recs.size() > 0)
            chk("abort_partial", recs[0].bits < 32, 1);

`ifdef SCI_READ_EN
        miso_pat = 16'hA5C3;
        run(1'b1, 1'b0, 32'h030B0000, 32'h0, 0, 1'b0);
        chk("sci_rdata", sci_rdata, 16'hA5C3);
        miso_pat = 16'h1234;
        run(1'b1, 1'b0, 32'h020B5555, 32'h0, 0, 1'b0);
        chk("sci_rdata_hold", sci_rdata, 16'hA5C3);
`endif

        for (int it = 0; it < 25; it++) begin
            wa   = $urandom;
            wb   = $urandom;
            mode = $urandom_range(0, 2);
            dly  = $urandom_range(0, 6);
            run(mode != 1, mode != 0, wa, wb, dly, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
